// File: rtl/board_loader_if.sv
// rtl/board_loader_if.sv - command, pattern stream and board write port of the board loader
interface board_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic                  start_in;
  logic                  clear_in;
  logic [ADDR_WIDTH-1:0] base_addr_in;
  logic                  word_valid_in;
  logic                  word_ready_out;
  logic [DATA_WIDTH-1:0] word_data_in;
  logic                  word_last_in;
  logic [ADDR_WIDTH-1:0] addr_w_out;
  logic [DATA_WIDTH-1:0] data_w_out;
  logic                  wr_en_out;
  logic                  busy_out;
  logic                  done_out;
  logic                  overflow_out;

  modport master (
    output start_in, clear_in, base_addr_in,
    output word_valid_in, word_data_in, word_last_in,
    input  word_ready_out,
    input  addr_w_out, data_w_out, wr_en_out,
    input  busy_out, done_out, overflow_out
  );

  modport slave (
    input  start_in, clear_in, base_addr_in,
    input  word_valid_in, word_data_in, word_last_in,
    output word_ready_out,
    output addr_w_out, data_w_out, wr_en_out,
    output busy_out, done_out, overflow_out
  );
endinterface

// File: rtl/board_loader.sv
// rtl/board_loader.sv - loads a board pattern (optionally after a full clear) into the double-buffer write port
module board_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WORDS  = 3600
) (
  input  logic         clk_in,
  input  logic         rst_in,
  board_loader_if.slave bus
);
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   WORDS_EXT = (ADDR_WIDTH + 1)'(NUM_WORDS);
  localparam logic [CW-1:0]         N_FULL    = CW'(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [CW-1:0]         n_cnt;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] data_w;
  logic                  wr_en;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic                  xfer;
  logic                  full;
  logic                  clr_end;

  assign xfer    = (state == LOAD) && bus.word_valid_in;
  assign full    = (n_cnt == N_FULL);
  assign clr_end = (clr_addr == LAST_ADDR);

  assign bus.word_ready_out = (state == LOAD);
  assign bus.addr_w_out     = addr_w;
  assign bus.data_w_out     = data_w;
  assign bus.wr_en_out      = wr_en;
  assign bus.busy_out       = busy;
  assign bus.done_out       = done;
  assign bus.overflow_out   = overflow;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start_in) state_next = bus.clear_in ? CLEAR : LOAD;
      CLEAR:   if (clr_end) state_next = LOAD;
      LOAD:    if (xfer && bus.word_last_in) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      clr_addr <= '0;
      ld_addr  <= '0;
      n_cnt    <= '0;
      addr_w   <= '0;
      data_w   <= '0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            busy     <= 1'b1;
            overflow <= 1'b0;
            n_cnt    <= '0;
            clr_addr <= '0;
            // An out-of-range base would never be reached by the wrap logic, so start at 0.
            ld_addr  <= ({1'b0, bus.base_addr_in} >= WORDS_EXT) ? '0 : bus.base_addr_in;
          end
        end
        CLEAR: begin
          wr_en    <= 1'b1;
          addr_w   <= clr_addr;
          data_w   <= '0;
          clr_addr <= clr_addr + ADDR_WIDTH'(1);
        end
        LOAD: begin
          if (xfer) begin
            // Past a full board the source is still drained, but nothing is written.
            if (full) begin
              overflow <= 1'b1;
            end else begin
              wr_en   <= 1'b1;
              addr_w  <= ld_addr;
              data_w  <= bus.word_data_in;
              ld_addr <= (ld_addr == LAST_ADDR) ? '0 : ld_addr + ADDR_WIDTH'(1);
              n_cnt   <= n_cnt + CW'(1);
            end
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
